// File: rtl/reg_dump_if.sv
// Word stream carrying one dumped register value (data plus its index)
// from the dump engine to the debug host.
interface reg_dump_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/reg_dump.sv
// Register-file dump engine: freezes the CPU, walks FIRST_REG..LAST_REG over the
// asynchronous read port and streams each value out with its index.
module reg_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    reg_dump_if.master  dump,
    output logic        freeze,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    state_t     state;
    logic [4:0] idx;

    // The read port is only driven while a value is being captured.
    assign rd_addr = (state == ST_READ) ? idx : 5'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            idx            <= 5'd0;
            dump.out_valid <= 1'b0;
            dump.out_data  <= 32'd0;
            dump.out_index <= 5'd0;
            freeze         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        idx    <= FIRST_IDX;
                        state  <= ST_READ;
                        freeze <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ST_READ: begin
                    dump.out_data  <= rd_data;
                    dump.out_index <= idx;
                    dump.out_valid <= 1'b1;
                    state          <= ST_SEND;
                end
                ST_SEND: begin
                    // idx stops at LAST_IDX, so a full 0..31 walk never wraps.
                    if (dump.out_ready) begin
                        dump.out_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    done   <= 1'b0;
                    freeze <= 1'b0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: a register-file model feeds the DUT and
// every dumped word and done pulse is checked against the expected image.
module tb_reg_dump;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        start5 = 1'b0;
    logic [4:0]  rd_addr, rd_addr5;
    logic [31:0] rd_data, rd_data5;
    logic        freeze, busy, done;
    logic        freeze5, busy5, done5;
    logic [31:0] regs [32];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int          hs_idx [$];
    logic [31:0] hs_data [$];
    int          done_cyc [$];
    int          overlap_cnt = 0;
    int          freeze_low_cnt = 0;
    int          stall_cnt = 0;
    bit          in_dump = 1'b0;

    reg_dump_if dump ();
    reg_dump_if dump5 ();

    assign rd_data  = (rd_addr == 5'd0)  ? 32'd0 : regs[rd_addr];
    assign rd_data5 = (rd_addr5 == 5'd0) ? 32'd0 : regs[rd_addr5];
    assign dump5.out_ready = 1'b1;

    reg_dump dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .dump    (dump),
        .freeze  (freeze),
        .busy    (busy),
        .done    (done)
    );

    reg_dump #(.FIRST_REG(5), .LAST_REG(5)) dut5 (
        .clock   (clock),
        .reset   (reset),
        .start   (start5),
        .rd_addr (rd_addr5),
        .rd_data (rd_data5),
        .dump    (dump5),
        .freeze  (freeze5),
        .busy    (busy5),
        .done    (done5)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Passive log of the main DUT's stream, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset) begin
            if (in_dump && !(freeze && busy)) freeze_low_cnt++;
            if (dump.out_valid && dump.out_ready) begin
                hs_idx.push_back(int'(dump.out_index));
                hs_data.push_back(dump.out_data);
            end
            if (dump.out_valid && !dump.out_ready) stall_cnt++;
            if (done && dump.out_valid) overlap_cnt++;
            if (done) begin
                done_cyc.push_back(cyc);
                in_dump = 1'b0;
            end
        end
    end

    // Expected image: register 0 always reads as zero.
    function automatic logic [31:0] model_word(input int i);
        return (i == 0) ? 32'd0 : regs[i];
    endfunction

    task automatic clear_log();
        hs_idx.delete();
        hs_data.delete();
        done_cyc.delete();
        overlap_cnt = 0;
        freeze_low_cnt = 0;
        stall_cnt = 0;
    endtask

    task automatic start_dump(output int s);
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        s = cyc;
        in_dump = 1'b1;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            #1;
            if (done_cyc.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_word(input int index, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            #1;
            if (dump.out_valid && int'(dump.out_index) == index) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (dump.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", dump.out_valid); end
        tests++;
        if (dump.out_data !== 32'd0) begin fails++; $display("[TB] FAIL reset_data: got %h expected 0", dump.out_data); end
        tests++;
        if (dump.out_index !== 5'd0) begin fails++; $display("[TB] FAIL reset_index: got %0d expected 0", dump.out_index); end
        tests++;
        if ({freeze, busy, done} !== 3'b000) begin fails++; $display("[TB] FAIL reset_flags: got %b expected 000", {freeze, busy, done}); end
        tests++;
        if (rd_addr !== 5'd0) begin fails++; $display("[TB] FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        tests++;
        if ({freeze, done, dump.out_valid} !== 3'b000) begin fails++; $display("[TB] FAIL idle_after_reset: got %b expected 000", {freeze, done, dump.out_valid}); end
    endtask

    task automatic test_full_dump();
        int s, d;
        bit ok;
        for (int i = 0; i < 32; i++) regs[i] = 32'h01010101 * i;
        regs[0] = $urandom;
        dump.out_ready = 1'b1;
        clear_log();
        start_dump(s);
        wait_done(200, ok);
        tests++;
        if (!ok) begin fails++; $display("[TB] FAIL full_done_timeout: got no done expected done"); end
        tests++;
        if (freeze !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL full_freeze_after: got %b%b expected 00", freeze, busy); end
        repeat (5) @(posedge clock);
        #1;
        tests++;
        if (hs_idx.size() != 32) begin fails++; $display("[TB] FAIL full_count: got %0d expected 32", hs_idx.size()); end
        for (int k = 0; k < hs_idx.size() && k < 32; k++) begin
            tests++;
            if (hs_idx[k] != k || hs_data[k] !== model_word(k)) begin
                fails++;
                $display("[TB] FAIL full_word%0d: got idx %0d data %h expected idx %0d data %h", k, hs_idx[k], hs_data[k], k, model_word(k));
            end
        end
        d = (done_cyc.size() > 0) ? done_cyc[0] - s : -1;
        tests++;
        if (done_cyc.size() != 1 || d != 64) begin fails++; $display("[TB] FAIL full_done_timing: got %0d pulses at +%0d expected 1 at +64", done_cyc.size(), d); end
        tests++;
        if (freeze_low_cnt != 0 || overlap_cnt != 0) begin fails++; $display("[TB] FAIL full_freeze_overlap: got %0d/%0d expected 0/0", freeze_low_cnt, overlap_cnt); end
    endtask

    task automatic test_backpressure();
        int s, d;
        bit ok;
        logic [31:0] held;
        dump.out_ready = 1'b1;
        clear_log();
        start_dump(s);
        wait_word(3, 50, ok);
        tests++;
        if (!ok) begin fails++; $display("[TB] FAIL bp_word3_timeout: got none expected index 3"); end
        dump.out_ready = 1'b0;
        held = dump.out_data;
        tests++;
        if (held !== model_word(3)) begin fails++; $display("[TB] FAIL bp_word3_data: got %h expected %h", held, model_word(3)); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            tests++;
            if (dump.out_valid !== 1'b1 || dump.out_index !== 5'd3 || dump.out_data !== held) begin
                fails++;
                $display("[TB] FAIL bp_hold%0d: got v%b idx %0d data %h expected v1 idx 3 data %h", i, dump.out_valid, dump.out_index, dump.out_data, held);
            end
        end
        dump.out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        tests++;
        if (dump.out_valid !== 1'b1 || dump.out_index !== 5'd4) begin fails++; $display("[TB] FAIL bp_next_word: got v%b idx %0d expected v1 idx 4", dump.out_valid, dump.out_index); end
        wait_done(200, ok);
        repeat (3) @(posedge clock);
        #1;
        tests++;
        if (hs_idx.size() != 32) begin fails++; $display("[TB] FAIL bp_count: got %0d expected 32", hs_idx.size()); end
        for (int k = 0; k < hs_idx.size() && k < 32; k++) begin
            tests++;
            if (hs_idx[k] != k || hs_data[k] !== model_word(k)) begin
                fails++;
                $display("[TB] FAIL bp_word%0d: got idx %0d data %h expected idx %0d data %h", k, hs_idx[k], hs_data[k], k, model_word(k));
            end
        end
        d = (done_cyc.size() > 0) ? done_cyc[0] - s : -1;
        tests++;
        if (done_cyc.size() != 1 || d != 69) begin fails++; $display("[TB] FAIL bp_done_timing: got %0d pulses at +%0d expected 1 at +69", done_cyc.size(), d); end
    endtask

    task automatic test_start_while_busy();
        int s, d;
        bit ok;
        dump.out_ready = 1'b1;
        clear_log();
        start_dump(s);
        wait_word(10, 50, ok);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_done(200, ok);
        repeat (10) @(posedge clock);
        #1;
        tests++;
        if (hs_idx.size() != 32 || done_cyc.size() != 1) begin fails++; $display("[TB] FAIL busy_start_counts: got %0d words %0d done expected 32 words 1 done", hs_idx.size(), done_cyc.size()); end
        d = (done_cyc.size() > 0) ? done_cyc[0] - s : -1;
        tests++;
        if (d != 64) begin fails++; $display("[TB] FAIL busy_start_timing: got +%0d expected +64", d); end
        tests++;
        if (freeze !== 1'b0) begin fails++; $display("[TB] FAIL busy_start_idle: got freeze %b expected 0", freeze); end
    endtask

    task automatic test_reset_mid_dump();
        int s;
        bit ok;
        dump.out_ready = 1'b1;
        clear_log();
        start_dump(s);
        wait_word(7, 50, ok);
        #2 reset = 1'b0;
        in_dump = 1'b0;
        #1;
        tests++;
        if ({dump.out_valid, freeze, busy, done} !== 4'b0000) begin fails++; $display("[TB] FAIL midreset_flags: got %b expected 0000", {dump.out_valid, freeze, busy, done}); end
        tests++;
        if (dump.out_data !== 32'd0 || dump.out_index !== 5'd0 || rd_addr !== 5'd0) begin fails++; $display("[TB] FAIL midreset_data: got %h/%0d/%0d expected 0/0/0", dump.out_data, dump.out_index, rd_addr); end
        @(negedge clock);
        reset = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        tests++;
        if (done_cyc.size() != 0) begin fails++; $display("[TB] FAIL midreset_no_done: got %0d expected 0", done_cyc.size()); end
        clear_log();
        start_dump(s);
        wait_done(200, ok);
        tests++;
        if (hs_idx.size() != 32 || hs_idx[0] != 0 || hs_data[0] !== 32'd0) begin fails++; $display("[TB] FAIL midreset_restart: got %0d words first idx %0d expected 32 words first idx 0", hs_idx.size(), (hs_idx.size() > 0) ? hs_idx[0] : -1); end
    endtask

    task automatic test_random_ready();
        int s, d;
        bit ok;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            dump.out_ready = 1'b1;
            clear_log();
            start_dump(s);
            ok = 1'b0;
            for (int c = 0; c < 1000 && !ok; c++) begin
                @(posedge clock);
                #1;
                dump.out_ready = ($urandom_range(0, 2) != 0);
                if (done_cyc.size() > 0) ok = 1'b1;
            end
            dump.out_ready = 1'b1;
            tests++;
            if (!ok) begin fails++; $display("[TB] FAIL rand%0d_timeout: got no done expected done", r); end
            tests++;
            if (hs_idx.size() != 32) begin fails++; $display("[TB] FAIL rand%0d_count: got %0d expected 32", r, hs_idx.size()); end
            for (int k = 0; k < hs_idx.size() && k < 32; k++) begin
                tests++;
                if (hs_idx[k] != k || hs_data[k] !== model_word(k)) begin
                    fails++;
                    $display("[TB] FAIL rand%0d_word%0d: got idx %0d data %h expected idx %0d data %h", r, k, hs_idx[k], hs_data[k], k, model_word(k));
                end
            end
            // Each stalled SEND cycle adds exactly one cycle to the 2-per-word pace.
            d = (done_cyc.size() > 0) ? done_cyc[0] - s : -1;
            tests++;
            if (d != 64 + stall_cnt) begin fails++; $display("[TB] FAIL rand%0d_timing: got +%0d expected +%0d", r, d, 64 + stall_cnt); end
            tests++;
            if (overlap_cnt != 0 || freeze_low_cnt != 0) begin fails++; $display("[TB] FAIL rand%0d_overlap_freeze: got %0d/%0d expected 0/0", r, overlap_cnt, freeze_low_cnt); end
        end
    endtask

    task automatic test_single_range();
        int s, words, done_n, done_at;
        logic [4:0]  got_idx;
        logic [31:0] got_data;
        regs[5] = 32'hDEADBEEF;
        words = 0;
        done_n = 0;
        done_at = -1;
        got_idx = 5'd0;
        got_data = 32'd0;
        @(posedge clock);
        #1 start5 = 1'b1;
        @(posedge clock);
        #1 start5 = 1'b0;
        s = cyc;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (dump5.out_valid) begin
                words++;
                got_idx = dump5.out_index;
                got_data = dump5.out_data;
            end
            if (done5) begin
                done_n++;
                done_at = cyc - s;
            end
        end
        tests++;
        if (words != 1) begin fails++; $display("[TB] FAIL single_count: got %0d expected 1", words); end
        tests++;
        if (got_idx !== 5'd5 || got_data !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL single_word: got idx %0d data %h expected idx 5 data deadbeef", got_idx, got_data); end
        tests++;
        if (done_n != 1 || done_at != 2) begin fails++; $display("[TB] FAIL single_done: got %0d pulses at +%0d expected 1 at +2", done_n, done_at); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        dump.out_ready = 1'b1;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_dump();
        test_random_ready();
        test_single_range();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
